// File: rtl/trigger_phase_capture.sv
// ---------------------------------------------------------------------------
// trigger_phase_capture
//
// Measures an asynchronous trigger against a bsync reference. The trigger is
// synchronized (s1, s2) and delayed once (s3) to find its rising edge. On the
// edge the clk-cycle distance from the last bsync_event is latched, then the
// trigger high time is counted. When the trigger falls the result is offered
// on a valid/ready output. A result that cannot be delivered because an
// earlier one is still pending is dropped and flagged in a sticky overflow.
//
// Ports
//   clk          in   clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   trig_in      in   external trigger, asynchronous to clk
//   ch_en        in   channel enable
//   bsync_event  in   one-cycle pulse on the bsync reference edge
//   bsync_ready  in   bsync alignment is valid
//   ovf_clr      in   one-cycle pulse clearing cap_ovf
//   cap_ready    in   consumer accepts the pending capture
//   cap_valid    out  a capture result is pending
//   cap_phase    out  [15:0] cycles from last bsync_event to the trigger edge
//   cap_width    out  [15:0] trigger high time in cycles
//   cap_count    out  [15:0] number of accepted captures (wraps)
//   cap_ovf      out  sticky flag, a result was dropped
//   cap_state    out  [2:0] current FSM state
// ---------------------------------------------------------------------------
module trigger_phase_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_in,
    input  logic        ch_en,
    input  logic        bsync_event,
    input  logic        bsync_ready,
    input  logic        ovf_clr,
    input  logic        cap_ready,
    output logic        cap_valid,
    output logic [15:0] cap_phase,
    output logic [15:0] cap_width,
    output logic [15:0] cap_count,
    output logic        cap_ovf,
    output logic [2:0]  cap_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ALIGN     = 3'd1,
        WAIT_EDGE = 3'd2,
        MEASURE   = 3'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic        s1_r;
    logic        s2_r;
    logic        s3_r;

    logic [15:0] phase_cnt_r;
    logic [15:0] phase_lat_r;
    logic [15:0] width_cnt_r;

    logic        en_ok_s;
    logic        trig_edge_s;
    logic [15:0] phase_now_s;
    logic        finish_s;
    logic        handshake_s;
    logic        load_s;
    logic        ovf_set_s;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc = 16'hFFFF;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

    // Trigger synchronizer and edge-delay stage; deliberately not reset so
    // the edge detector never sees a false edge coming out of reset.
    always_ff @(posedge clk) begin
        s1_r <= trig_in;
        s2_r <= s1_r;
        s3_r <= s2_r;
    end

    // Datapath decode: edge detect, phase value and capture hand-off terms.
    always_comb begin
        en_ok_s     = ch_en & bsync_ready;
        trig_edge_s = s2_r & ~s3_r;
        phase_now_s = bsync_event ? 16'd0 : phase_cnt_r;
        // Normal end of a pulse; a disable mid-pulse never reaches here.
        finish_s    = (state_r == MEASURE) & en_ok_s & ~s2_r;
        handshake_s = cap_valid & cap_ready;
        load_s      = finish_s & (~cap_valid | cap_ready);
        ovf_set_s   = finish_s & cap_valid & ~cap_ready;
    end

    // Next-state logic; losing enable or alignment overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (!en_ok_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:      state_next_s = ALIGN;
                ALIGN:     state_next_s = bsync_event ? WAIT_EDGE : ALIGN;
                WAIT_EDGE: state_next_s = trig_edge_s ? MEASURE : WAIT_EDGE;
                MEASURE:   state_next_s = s2_r ? MEASURE : WAIT_EDGE;
                default:   state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Phase counter: runs only once aligned, restarts on every bsync_event.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt_r <= 16'd0;
        end else if ((state_r == WAIT_EDGE) || (state_r == MEASURE)) begin
            phase_cnt_r <= sat_inc(phase_now_s);
        end else begin
            phase_cnt_r <= 16'd0;
        end
    end

    // Phase latch and width counter; the edge cycle itself counts as 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_lat_r <= 16'd0;
            width_cnt_r <= 16'd0;
        end else if ((state_r == WAIT_EDGE) && en_ok_s && trig_edge_s) begin
            phase_lat_r <= phase_now_s;
            width_cnt_r <= 16'd1;
        end else if ((state_r == MEASURE) && en_ok_s && s2_r) begin
            width_cnt_r <= sat_inc(width_cnt_r);
        end
    end

    // Output result registers, acceptance counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_phase <= 16'd0;
            cap_width <= 16'd0;
            cap_count <= 16'd0;
            cap_ovf   <= 1'b0;
        end else begin
            if (load_s) begin
                cap_phase <= phase_lat_r;
                cap_width <= width_cnt_r;
            end
            // A new load wins over the clear from a same-cycle acceptance.
            if (load_s) begin
                cap_valid <= 1'b1;
            end else if (handshake_s) begin
                cap_valid <= 1'b0;
            end
            if (handshake_s) begin
                cap_count <= cap_count + 16'd1;
            end
            // Overflow wins over a same-cycle clear.
            if (ovf_set_s) begin
                cap_ovf <= 1'b1;
            end else if (ovf_clr) begin
                cap_ovf <= 1'b0;
            end
        end
    end

    assign cap_state = state_r;

endmodule

// File: doc/trigger_phase_capture.md
TRIGGER_PHASE_CAPTURE -- requirements
Module: trigger_phase_capture

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have the port trig_in, input, 1 bit: external trigger, asynchronous to clk.
REQ-004 The module SHALL have the port ch_en, input, 1 bit: channel enable.
REQ-005 The module SHALL have the port bsync_event, input, 1 bit: one-cycle pulse marking the bsync reference edge.
REQ-006 The module SHALL have the port bsync_ready, input, 1 bit: bsync alignment is valid.
REQ-007 The module SHALL have the port ovf_clr, input, 1 bit: one-cycle pulse that clears the overflow flag.
REQ-008 The module SHALL have the port cap_ready, input, 1 bit: consumer accepts the capture.
REQ-009 The module SHALL have the port cap_valid, output, 1 bit: a capture result is pending.
REQ-010 The module SHALL have the port cap_phase, output, 16 bits: clk cycles from the last bsync_event to the trigger edge.
REQ-011 The module SHALL have the port cap_width, output, 16 bits: trigger high time in clk cycles.
REQ-012 The module SHALL have the port cap_count, output, 16 bits: number of accepted captures.
REQ-013 The module SHALL have the port cap_ovf, output, 1 bit: sticky flag, set when a result is dropped.
REQ-014 The module SHALL have the port cap_state, output, 3 bits: current FSM state.

Function
REQ-015 trig_in SHALL pass through a 2-FF synchronizer (s1, s2) followed by a delay register s3.
  - trig_edge = s2 & !s3.
  - The synchronizer SHALL run regardless of rst and state.
REQ-016 The FSM SHALL use these state encodings: IDLE=0, ALIGN=1, WAIT_EDGE=2, MEASURE=3; unused encodings SHALL go to IDLE.
REQ-017 If ch_en=0 or bsync_ready=0, the next state SHALL be IDLE from any state; this rule has priority over all other transitions.
REQ-018 The FSM SHALL make these transitions:
  - IDLE->ALIGN when ch_en & bsync_ready.
  - ALIGN->WAIT_EDGE on bsync_event.
  - WAIT_EDGE->MEASURE on trig_edge.
  - MEASURE->WAIT_EDGE when s2=0.
REQ-019 The phase counter SHALL behave as follows:
  - phase_now = bsync_event ? 0 : phase_cnt.
  - phase_cnt <= phase_now+1, saturating at 0xFFFF.
  - phase_cnt SHALL be held at 0 in IDLE and ALIGN.
REQ-020 In WAIT_EDGE, on trig_edge, the module SHALL latch phase_now into an internal phase register and set the width counter to 1.
REQ-021 In MEASURE, the width counter SHALL increment each cycle that s2=1, saturating at 0xFFFF.
REQ-022 On the MEASURE->WAIT_EDGE transition, the module SHALL complete the capture as follows:
  - If cap_valid=0, or cap_valid & cap_ready: load cap_phase and cap_width; cap_valid=1 next cycle.
  - Else: discard the result, keep the pending outputs unchanged, and set cap_ovf.
REQ-023 cap_valid SHALL clear on a cycle with cap_valid & cap_ready, unless REQ-022 loads a new result in the same cycle, in which case it stays 1.
  - cap_count SHALL increment, mod 2^16, on each cap_valid & cap_ready cycle.
REQ-024 cap_phase and cap_width SHALL remain stable while cap_valid=1 and cap_ready=0.
REQ-025 ovf_clr SHALL clear cap_ovf; if ovf_clr and an overflow occur in the same cycle, cap_ovf SHALL end at 1.
REQ-026 Leaving MEASURE via REQ-017 (disable mid-pulse) SHALL discard the in-progress measurement with no load and no overflow.
  - Pending cap_valid, cap_phase, cap_width, cap_count and cap_ovf SHALL be retained.
REQ-027 If trig_in is already high on entry to WAIT_EDGE, no capture SHALL occur until a low-to-high transition is seen.
REQ-028 If bsync_event and trig_edge occur in the same cycle, the captured phase SHALL be 0.
REQ-029 The raw phase SHALL include the fixed 2-cycle synchronizer latency; the block SHALL NOT compensate for it.

Reset
REQ-030 While rst=1, the module SHALL hold:
  - State IDLE.
  - cap_valid=0, cap_phase=0, cap_width=0, cap_count=0, cap_ovf=0.
  - phase_cnt=0, width counter=0.
REQ-031 cap_state SHALL read 0 during reset and in the first cycle after reset.

Verification
REQ-032 Basic capture:
  - Stimulus: ch_en=bsync_ready=1; bsync_event every 100 cycles; trig_in rises 37 cycles after an event and stays high 10 cycles; cap_ready=1.
  - Response: cap_valid pulses 1 cycle; cap_phase=39 (37+2 synchronizer); cap_width=10; cap_count=1.
REQ-033 Backpressure and overflow:
  - Stimulus: cap_ready=0; two complete triggers.
  - Response: the first result is held unchanged and cap_ovf=1 after the second pulse ends.
  - Then: ovf_clr pulse -> cap_ovf=0; one cap_ready cycle -> cap_valid=0, cap_count=1.
REQ-034 Coincident edge: trig_edge in the same cycle as bsync_event -> cap_phase=0.
REQ-035 Saturation: a trigger held high 70000 cycles, with no bsync_event for 70000 cycles before the edge -> cap_width=0xFFFF, cap_phase=0xFFFF.
REQ-036 Mid-pulse disable and reset:
  - Stimulus: ch_en drops during MEASURE.
  - Response: cap_state=0 next cycle; no cap_valid; prior outputs retained.
  - Then: rst=1 for 1 cycle -> all outputs 0.
